// File: rtl/reg_writeback_queue.sv
// Write-back request FIFO in front of the 32x32 register bank. It drains one
// entry per clock into the bank write port and forwards pending data to readers.
module reg_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_reg,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     hold,
    output logic                     RegEn,
    output logic [ADDR_W-1:0]        WriteReg,
    output logic [DATA_W-1:0]        WriteData,
    input  logic [ADDR_W-1:0]        LookReg,
    output logic                     LookHit,
    output logic [DATA_W-1:0]        LookData,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic push, pop, not_empty;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    // Writes to register 0 are consumed by the handshake but never stored.
    assign push      = in_valid && in_ready && (in_reg != '0);
    assign pop       = not_empty && !hold;

    assign RegEn     = pop;
    assign WriteReg  = not_empty ? reg_q[rd_ptr_q]  : '0;
    assign WriteData = not_empty ? data_q[rd_ptr_q] : '0;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                reg_q[wr_ptr_q]  <= in_reg;
                data_q[wr_ptr_q] <= in_data;
            end
        end
    end

    // Per-slot match: a slot is live when its age from the head is below count.
    logic [DEPTH-1:0] slot_match;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] age;
            assign age = PTR_W'(gi) - rd_ptr_q;
            assign slot_match[gi] = ({1'b0, age} < count_q) && (reg_q[gi] == LookReg);
        end
    endgenerate

    // Walk oldest to youngest so the youngest match is the one left standing.
    logic [PTR_W-1:0] look_idx;
    always_comb begin
        LookHit  = 1'b0;
        LookData = '0;
        look_idx = '0;
        if (LookReg != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                look_idx = rd_ptr_q + PTR_W'(i);
                if (slot_match[look_idx]) begin
                    LookHit  = 1'b1;
                    LookData = data_q[look_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: drain order, backpressure, register 0,
// forwarding priority and asynchronous reset, all against hand-computed values.
module tb_reg_writeback_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_reg = '0;
    logic [31:0] in_data = '0;
    logic        hold = 1'b0;
    logic        RegEn;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  LookReg = '0;
    logic        LookHit;
    logic [31:0] LookData;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .hold(hold),
        .RegEn(RegEn), .WriteReg(WriteReg), .WriteData(WriteData),
        .LookReg(LookReg), .LookHit(LookHit), .LookData(LookData),
        .count(count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance past the next rising edge; outputs then reflect the new state.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic en, input logic [4:0] r,
                               input logic [31:0] d);
        #1;
        check({tag, ".RegEn"}, 64'(RegEn), 64'(en));
        check({tag, ".WriteReg"}, 64'(WriteReg), 64'(r));
        check({tag, ".WriteData"}, 64'(WriteData), 64'(d));
    endtask

    initial begin
        // Asynchronous reset mid-cycle, observed before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        check("rst.RegEn", 64'(RegEn), 64'd0);
        check("rst.count", 64'(count), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.LookHit", 64'(LookHit), 64'd0);
        check("rst.WriteReg", 64'(WriteReg), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single write, empty queue, hold low.
        push(5'd3, 32'h0000_00AA);
        LookReg = 5'd3;
        expect_head("single", 1'b1, 5'd3, 32'hAA);
        check("single.count", 64'(count), 64'd1);
        check("single.LookData", 64'(LookData), 64'hAA);
        step();
        expect_head("single.after", 1'b0, 5'd0, 32'd0);
        check("single.count0", 64'(count), 64'd0);

        // Fill under hold, then a fifth push is refused.
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 32'h11));
        #1;
        check("fill.count", 64'(count), 64'd4);
        check("fill.in_ready", 64'(in_ready), 64'd0);
        check("fill.RegEn", 64'(RegEn), 64'd0);
        push(5'd9, 32'h99);
        check("fill.count_after5", 64'(count), 64'd4);
        hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            expect_head($sformatf("drain%0d", i), 1'b1, 5'(i), 32'(i * 32'h11));
            step();
        end
        expect_head("drain.empty", 1'b0, 5'd0, 32'd0);

        // Forwarding: youngest match wins; in-flight accept is invisible.
        hold = 1'b1;
        push(5'd5, 32'h100);
        push(5'd5, 32'h200);
        push(5'd6, 32'h300);
        LookReg = 5'd5; #1;
        check("fwd5.hit", 64'(LookHit), 64'd1);
        check("fwd5.data", 64'(LookData), 64'h200);
        LookReg = 5'd6; #1;
        check("fwd6.data", 64'(LookData), 64'h300);
        LookReg = 5'd7;
        in_valid = 1'b1; in_reg = 5'd7; in_data = 32'h700; #1;
        check("fwd7.pending_hit", 64'(LookHit), 64'd0);
        check("fwd7.pending_data", 64'(LookData), 64'd0);
        step();
        in_valid = 1'b0; #1;
        check("fwd7.hit", 64'(LookHit), 64'd1);
        check("fwd7.data", 64'(LookData), 64'h700);
        LookReg = 5'd0; #1;
        check("fwd0.hit", 64'(LookHit), 64'd0);
        hold = 1'b0;
        LookReg = 5'd5;
        expect_head("fdrain1", 1'b1, 5'd5, 32'h100);
        check("fdrain1.look", 64'(LookData), 64'h200);
        step();
        expect_head("fdrain2", 1'b1, 5'd5, 32'h200);
        step();
        expect_head("fdrain3", 1'b1, 5'd6, 32'h300);
        check("fdrain3.lookmiss", 64'(LookHit), 64'd0);
        step();
        expect_head("fdrain4", 1'b1, 5'd7, 32'h700);
        step();
        check("fdrain.count", 64'(count), 64'd0);

        // Register 0 is consumed but not queued.
        in_valid = 1'b1; in_reg = 5'd0; in_data = 32'hDEAD; #1;
        check("r0.in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        expect_head("r0.after", 1'b0, 5'd0, 32'd0);
        check("r0.count", 64'(count), 64'd0);

        // Simultaneous push/pop at count 2; data for reg r is (r-10)*0x10+0xA0.
        hold = 1'b1;
        push(5'd10, 32'hA0);
        push(5'd11, 32'hB0);
        hold = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_reg   = 5'(12 + k);
            in_data  = 32'(32'hC0 + 32'h10 * k);
            expect_head($sformatf("pp%0d", k), 1'b1, 5'(10 + k), 32'(32'hA0 + 32'h10 * k));
            check($sformatf("pp%0d.count", k), 64'(count), 64'd2);
            step();
        end
        in_valid = 1'b0;
        expect_head("pp.tail0", 1'b1, 5'd16, 32'h100);
        step();
        expect_head("pp.tail1", 1'b1, 5'd17, 32'h110);
        step();
        check("pp.count", 64'(count), 64'd0);

        // Reset with three pending writes: nothing reaches the bank.
        hold = 1'b1;
        push(5'd20, 32'h2000);
        push(5'd21, 32'h2100);
        push(5'd22, 32'h2200);
        hold = 1'b0;
        LookReg = 5'd20;
        expect_head("mrst.before", 1'b1, 5'd20, 32'h2000);
        rst_n = 1'b0;
        expect_head("mrst.in", 1'b0, 5'd0, 32'd0);
        check("mrst.count", 64'(count), 64'd0);
        check("mrst.in_ready", 64'(in_ready), 64'd1);
        check("mrst.LookHit", 64'(LookHit), 64'd0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_head($sformatf("mrst.idle%0d", k), 1'b0, 5'd0, 32'd0);
        end
        check("mrst.LookData", 64'(LookData), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
